// File: rtl/clock_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_disp_pkg
//  Purpose  : Shared types and constants for the six-digit scan display.
//             Provides the FSM state enum, the 7-segment patterns and the
//             digit index map.
//  Revision : 1.0 - initial release
// ============================================================================
package clock_disp_pkg;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Active-low segment patterns, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Scan order: seconds first, hour tens last
    localparam logic [2:0] IDX_SEC_ONES  = 3'd0;
    localparam logic [2:0] IDX_SEC_TENS  = 3'd1;
    localparam logic [2:0] IDX_MIN_ONES  = 3'd2;
    localparam logic [2:0] IDX_MIN_TENS  = 3'd3;
    localparam logic [2:0] IDX_HOUR_ONES = 3'd4;
    localparam logic [2:0] IDX_HOUR_TENS = 3'd5;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decode
//  Purpose  : BCD digit to active-low 7-segment pattern. Dash overrides
//             blank, blank overrides the digit; codes above 9 show blank.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
    import clock_disp_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    input  logic       i_dash,
    output logic [6:0] o_seg
);

    // Priority select between dash, blank and the digit glyph
    always_comb begin
        o_seg = SEG_BLANK;
        if (i_dash) begin
            o_seg = SEG_DASH;
        end else if (!i_blank) begin
            case (i_digit)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/clock_disp_scan.sv
`default_nettype none
// ============================================================================
//  Module   : clock_disp_scan
//  Purpose  : Six-digit multiplexed 7-segment driver for HH MM SS. Snapshots
//             the binary time once per frame (LOAD), then scans the digits
//             one by one (SCAN) with a blinking separator dot.
//  Revision : 1.0 - initial release
// ============================================================================
module clock_disp_scan
    import clock_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 1,
    parameter int BLINK_FRAMES = 83,
    parameter int HOUR_LZB     = 1
) (
    input  logic       clk_1KHZ,
    input  logic       rst,
    input  logic [6:0] hour_in,
    input  logic [6:0] min_in,
    input  logic [6:0] sec_in,
    input  logic       blink_en,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int c_DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_FCNT_W-1:0] c_FCNT_LAST = c_FCNT_W'(BLINK_FRAMES - 1);

    state_t              r_state;
    logic [6:0]          r_hour;
    logic [6:0]          r_min;
    logic [6:0]          r_sec;
    logic [2:0]          r_idx;
    logic [c_DIV_W-1:0]  r_div;
    logic [c_FCNT_W-1:0] r_fcnt;
    logic                r_phase;

    logic [6:0]          w_val;
    logic [3:0]          w_tens;
    logic [3:0]          w_ones;
    logic [3:0]          w_digit;
    logic                w_over;
    logic                w_lzb_blank;
    logic                w_blank;
    logic                w_dash;

    // Frame FSM: one LOAD cycle snapshots inputs, then SCAN walks six digits
    always_ff @(posedge clk_1KHZ) begin
        if (rst) begin
            r_state <= ST_LOAD;
            r_hour  <= '0;
            r_min   <= '0;
            r_sec   <= '0;
            r_idx   <= IDX_SEC_ONES;
            r_div   <= '0;
            r_fcnt  <= '0;
            r_phase <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_hour  <= hour_in;
                    r_min   <= min_in;
                    r_sec   <= sec_in;
                    r_idx   <= IDX_SEC_ONES;
                    r_div   <= '0;
                    r_state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (r_div == c_DIV_LAST) begin
                        r_div <= '0;
                        if (r_idx == IDX_HOUR_TENS) begin
                            // Frame complete: advance the blink timebase
                            r_state <= ST_LOAD;
                            if (r_fcnt == c_FCNT_LAST) begin
                                r_fcnt  <= '0;
                                r_phase <= ~r_phase;
                            end else begin
                                r_fcnt <= r_fcnt + 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    // Pick the snapshot feeding the current digit and split it into BCD
    always_comb begin
        case (r_idx)
            IDX_SEC_ONES, IDX_SEC_TENS:   w_val = r_sec;
            IDX_MIN_ONES, IDX_MIN_TENS:   w_val = r_min;
            default:                      w_val = r_hour;
        endcase
        w_over      = (w_val > 7'd99);
        w_tens      = 4'(w_val / 7'd10);
        w_ones      = 4'(w_val % 7'd10);
        w_digit     = r_idx[0] ? w_tens : w_ones;
        w_lzb_blank = (HOUR_LZB != 0) && (r_idx == IDX_HOUR_TENS) && (w_tens == 4'd0);
        w_blank     = (r_state == ST_LOAD) || w_lzb_blank;
        w_dash      = (r_state == ST_SCAN) && w_over;
    end

    seg7_decode u_seg7_decode (
        .i_digit (w_digit),
        .i_blank (w_blank),
        .i_dash  (w_dash),
        .o_seg   (seg)
    );

    // Moore decode of digit enables, separator dot and frame marker
    always_comb begin
        an          = (r_state == ST_SCAN) ? ~(6'b000001 << r_idx) : 6'b111111;
        dp          = ~((r_state == ST_SCAN) &&
                        ((r_idx == IDX_MIN_ONES) || (r_idx == IDX_HOUR_ONES)) &&
                        (!blink_en || r_phase));
        frame_start = (r_state == ST_LOAD);
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_disp_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_disp_scan
//  Purpose  : Directed scoreboard bench for clock_disp_scan. Main instance
//             uses SCAN_DIV=1, BLINK_FRAMES=2, HOUR_LZB=1; a second instance
//             uses SCAN_DIV=3, BLINK_FRAMES=1, HOUR_LZB=0.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clock_disp_scan;

    localparam int BLINK = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] hour_in, min_in, sec_in;
    logic       blink_en;
    logic [5:0] an, an2;
    logic [6:0] seg, seg2;
    logic       dp, dp2, fs, fs2;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   m_fcnt  = 0;
    logic m_phase = 1'b0;
    int   fnum    = 0;

    always #5 clk = ~clk;

    clock_disp_scan #(.SCAN_DIV(1), .BLINK_FRAMES(BLINK), .HOUR_LZB(1)) u_dut (
        .clk_1KHZ (clk), .rst (rst), .hour_in (hour_in), .min_in (min_in),
        .sec_in (sec_in), .blink_en (blink_en), .an (an), .seg (seg),
        .dp (dp), .frame_start (fs)
    );

    clock_disp_scan #(.SCAN_DIV(3), .BLINK_FRAMES(1), .HOUR_LZB(0)) u_dut2 (
        .clk_1KHZ (clk), .rst (rst), .hour_in (hour_in), .min_in (min_in),
        .sec_in (sec_in), .blink_en (blink_en), .an (an2), .seg (seg2),
        .dp (dp2), .frame_start (fs2)
    );

    function automatic logic [6:0] pat(int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic exp_t load_exp();
        exp_t e;
        e.an = 6'b111111; e.seg = 7'b1111111; e.dp = 1'b1; e.fs = 1'b1;
        return e;
    endfunction

    function automatic exp_t digit_exp(int k, int h, int m, int s, bit lzb,
                                       logic ph, logic be);
        exp_t e;
        int   v;
        int   d;
        v = (k < 2) ? s : ((k < 4) ? m : h);
        d = (k % 2 == 1) ? (v / 10) : (v % 10);
        e.an    = 6'b111111;
        e.an[k] = 1'b0;
        if (v > 99)                     e.seg = 7'b0111111;
        else if (k == 5 && lzb && d == 0) e.seg = 7'b1111111;
        else                            e.seg = pat(d);
        e.dp = ((k == 2 || k == 4) && (!be || ph)) ? 1'b0 : 1'b1;
        e.fs = 1'b0;
        return e;
    endfunction

    task automatic chk(string tag, logic [6:0] obs, logic [6:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic pop_cmp(string tag, logic [5:0] a, logic [6:0] sg,
                           logic d, logic f);
        exp_t e;
        e = q.pop_front();
        chk({tag, ".an"},  {1'b0, a},    {1'b0, e.an});
        chk({tag, ".seg"}, sg,           e.seg);
        chk({tag, ".dp"},  {6'd0, d},    {6'd0, e.dp});
        chk({tag, ".fs"},  {6'd0, f},    {6'd0, e.fs});
    endtask

    // Entered at the negedge of a LOAD cycle; leaves at the next LOAD negedge
    task automatic run_frame(int h, int m, int s, logic be,
                             int chg_c, int chg_s, int abort_c);
        hour_in  = 7'(h);
        min_in   = 7'(m);
        sec_in   = 7'(s);
        blink_en = be;
        q.push_back(load_exp());
        for (int k = 0; k < 6; k++) q.push_back(digit_exp(k, h, m, s, 1'b1, m_phase, be));
        for (int c = 0; c < 7; c++) begin
            if (c == chg_c) sec_in = 7'(chg_s);
            pop_cmp($sformatf("f%0d.c%0d", fnum, c), an, seg, dp, fs);
            if (c == abort_c) begin
                rst = 1'b1;
                q.delete();
                @(negedge clk);
                rst     = 1'b0;
                m_fcnt  = 0;
                m_phase = 1'b0;
                fnum++;
                return;
            end
            @(negedge clk);
        end
        if (m_fcnt == BLINK - 1) begin
            m_fcnt  = 0;
            m_phase = ~m_phase;
        end else begin
            m_fcnt++;
        end
        fnum++;
    endtask

    initial begin
        rst      = 1'b1;
        hour_in  = 7'd12;
        min_in   = 7'd34;
        sec_in   = 7'd56;
        blink_en = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state while rst is held
        q.push_back(load_exp());
        pop_cmp("reset", an, seg, dp, fs);
        rst = 1'b0;

        run_frame(12,  34,  56, 1'b1, -1,  0, -1);   // basic 12:34:56
        run_frame(5,   34,  56, 1'b1,  1, 67, -1);   // hour LZB, sec changes mid-scan
        run_frame(5,  100,  67, 1'b1, -1,  0, -1);   // minute dash, phase 1
        run_frame(23,  59,  59, 1'b1, -1,  0, -1);   // phase 1 again
        run_frame(127,  0,   9, 1'b0, -1,  0, -1);   // hour dash, steady dots
        run_frame(0,    0,   0, 1'b1, -1,  0, -1);   // all zeros, hour tens blank
        run_frame(45,   7,  30, 1'b1, -1,  0,  4);   // reset while idx=3
        run_frame(8,    9,  10, 1'b1, -1,  0, -1);   // phase back to 0
        run_frame(99,  99,  99, 1'b0, -1,  0, -1);   // upper in-range bound

        // Second instance: SCAN_DIV=3, no leading-zero blanking, blink every frame
        rst      = 1'b1;
        hour_in  = 7'd5;
        min_in   = 7'd42;
        sec_in   = 7'd17;
        blink_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int f = 0; f < 2; f++) begin
            q.push_back(load_exp());
            for (int k = 0; k < 6; k++)
                for (int r = 0; r < 3; r++)
                    q.push_back(digit_exp(k, 5, 42, 17, 1'b0, logic'(f % 2), 1'b1));
            for (int c = 0; c < 19; c++) begin
                pop_cmp($sformatf("d2.f%0d.c%0d", f, c), an2, seg2, dp2, fs2);
                @(negedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
